mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  reset (synchronous, active-high); rdy  in  1  global enable, all state frozen when low.
REQ-002 SHALL have instruction-port inputs: i_rw_flag  in  2  [0] read, [1] write, 00 idle; i_addr  in  32  byte address; i_len  in  2  access length code.
REQ-003 SHALL have instruction-port outputs: i_data_out  out  32  read result; i_busy  out  1  request accepted/waiting; i_done  out  1  one-cycle completion pulse.
REQ-004 SHALL have data-port inputs: d_rw_flag  in  2; d_addr  in  32; d_len  in  2; d_wdata  in  32  store data.
REQ-005 SHALL have data-port outputs: d_data_out  out  32; d_busy  out  1; d_done  out  1.
REQ-006 SHALL have memory-side outputs: rw_flag_out  out  2; addr_out  out  32; len_out  out  2; wdata_out  out  32.
REQ-007 SHALL have memory-side inputs: read_data  in  32; mem_busy  in  1; mem_done  in  1  one-cycle completion from mem_ctrl.
REQ-008 SHALL drive all outputs from registers; no combinational input-to-output path.

Function
REQ-009 SHALL implement states IDLE, SERVE_I, SERVE_D (2-bit register) plus 1-bit last_grant (0 = I, 1 = D).
REQ-010 In IDLE, a port is eligible when its rw_flag != 00 and it is not the port whose done is high this cycle (just-served mask).
REQ-011 In IDLE, one eligible port SHALL be granted: that port; both eligible: the port != last_grant (round-robin).
REQ-012 On grant, SHALL register addr/len/rw_flag (and d_wdata for D, zero for I) to memory outputs, set last_grant, set granted busy=1, enter SERVE_x.
REQ-013 rw_flag_out SHALL be nonzero for exactly the one cycle after the grant edge, 00 otherwise; addr_out/len_out/wdata_out held until next grant.
REQ-014 In SERVE_x without mem_done: hold state, busy_x=1, done_x=0, rw_flag_out=00; mem_busy is ignored for sequencing.
REQ-015 In SERVE_x with mem_done: x_data_out <= read_data, done_x <= 1 for one cycle, busy_x <= 0, return to IDLE.
REQ-016 x_data_out SHALL hold its value until that port's next completion; writes also update x_data_out with read_data.
REQ-017 A port not granted SHALL keep busy=0 and done=0 while its request waits; requesters hold rw_flag/addr/len/wdata stable until their done.
REQ-018 Earliest re-grant: cycle after done; minimum request-to-done latency = 2 cycles + memory latency.
REQ-019 mem_done arriving in IDLE SHALL be ignored (no done pulse, no data update).
REQ-020 rdy low SHALL freeze all registers including outputs; a mem_done arriving while rdy low is lost by design (mem_ctrl shares rdy).
REQ-021 Requests changing while in SERVE_x SHALL not affect the transaction in flight.

Reset
REQ-022 On rst (priority over rdy): state=IDLE, last_grant=1 (D), all outputs 0, including data_out, busy, done, rw_flag_out.
REQ-023 rst mid-transaction SHALL abandon it: no done pulse, IDLE next cycle, subsequent mem_done ignored.

Verification
REQ-024 I read only: i_rw_flag=01, i_addr=0x1000; mem_done with read_data=0xDEADBEEF 3 cycles after issue -> rw_flag_out=01 one cycle, addr_out=0x1000, i_done one cycle, i_data_out=0xDEADBEEF.
REQ-025 Simultaneous I read 0x2000 and D write 0x3000/0x55 after reset -> I granted first (last_grant=1), then D issued cycle after i_done with wdata_out=0x55.
REQ-026 Both held continuously across 4 transactions -> grants alternate I,D,I,D; no port served twice consecutively.
REQ-027 I held high through its done cycle, D idle -> no duplicate issue in done cycle; re-grant to I cycle after.
REQ-028 rst asserted in SERVE_D, mem_done follows -> d_done stays 0, all outputs 0, next request served normally.
REQ-029 rdy low 2 cycles mid-SERVE_I (mem_done held off) -> state, busy, addr_out unchanged; completes normally after rdy returns.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) round-robin arbiter in front of a
// single memory controller. One transaction in flight at a time; every output
// is a register, so nothing on an input reaches an output in the same cycle.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    // instruction port
    input  logic [1:0]  i_rw_flag,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_len,
    output logic [31:0] i_data_out,
    output logic        i_busy,
    output logic        i_done,
    // data port
    input  logic [1:0]  d_rw_flag,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_len,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_data_out,
    output logic        d_busy,
    output logic        d_done,
    // memory side
    output logic [1:0]  rw_flag_out,
    output logic [31:0] addr_out,
    output logic [1:0]  len_out,
    output logic [31:0] wdata_out,
    input  logic [31:0] read_data,
    input  logic        mem_busy,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;   // 0 = I served last, 1 = D served last

    // The controller sequences purely on mem_done; mem_busy is informational.
    logic   unused_mem_busy;
    assign unused_mem_busy = mem_busy;

    // A port whose done pulse is high this cycle is still holding the request
    // it just completed, so it is masked to avoid re-issuing it.
    logic i_elig, d_elig, grant_i, grant_d;
    assign i_elig  = (i_rw_flag != 2'b00) && !i_done;
    assign d_elig  = (d_rw_flag != 2'b00) && !d_done;
    assign grant_i = i_elig && (!d_elig || last_grant);
    assign grant_d = d_elig && (!i_elig || !last_grant);

    // Arbitration FSM with all outputs registered; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            i_data_out  <= 32'd0;
            i_busy      <= 1'b0;
            i_done      <= 1'b0;
            d_data_out  <= 32'd0;
            d_busy      <= 1'b0;
            d_done      <= 1'b0;
            rw_flag_out <= 2'b00;
            addr_out    <= 32'd0;
            len_out     <= 2'b00;
            wdata_out   <= 32'd0;
        end else if (rdy) begin
            // issue strobe and done pulses last a single cycle
            rw_flag_out <= 2'b00;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        rw_flag_out <= i_rw_flag;
                        addr_out    <= i_addr;
                        len_out     <= i_len;
                        wdata_out   <= 32'd0;
                        last_grant  <= 1'b0;
                        i_busy      <= 1'b1;
                        state       <= SERVE_I;
                    end else if (grant_d) begin
                        rw_flag_out <= d_rw_flag;
                        addr_out    <= d_addr;
                        len_out     <= d_len;
                        wdata_out   <= d_wdata;
                        last_grant  <= 1'b1;
                        d_busy      <= 1'b1;
                        state       <= SERVE_D;
                    end
                end
                SERVE_I: begin
                    if (mem_done) begin
                        i_data_out <= read_data;
                        i_done     <= 1'b1;
                        i_busy     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                SERVE_D: begin
                    if (mem_done) begin
                        d_data_out <= read_data;
                        d_done     <= 1'b1;
                        d_busy     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic. A
// reference model predicts per-cycle port status and pushes expected memory
// issues and completion data into queues; a separate monitor pops them.
module tb_mem_arbiter;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic [1:0]  i_rw_flag = 2'b00, i_len = 2'b00;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_data_out;
    logic        i_busy, i_done;
    logic [1:0]  d_rw_flag = 2'b00, d_len = 2'b00;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic [31:0] d_data_out;
    logic        d_busy, d_done;
    logic [1:0]  rw_flag_out, len_out;
    logic [31:0] addr_out, wdata_out;
    logic [31:0] read_data = 32'd0;
    logic        mem_busy = 1'b0, mem_done = 1'b0;
    logic        mem_manual = 1'b1;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .i_rw_flag(i_rw_flag), .i_addr(i_addr), .i_len(i_len),
        .i_data_out(i_data_out), .i_busy(i_busy), .i_done(i_done),
        .d_rw_flag(d_rw_flag), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
        .d_data_out(d_data_out), .d_busy(d_busy), .d_done(d_done),
        .rw_flag_out(rw_flag_out), .addr_out(addr_out), .len_out(len_out),
        .wdata_out(wdata_out), .read_data(read_data), .mem_busy(mem_busy),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wd;
    } iss_t;

    iss_t        q_iss[$];
    logic [31:0] q_di[$];
    logic [31:0] q_dd[$];

    // ---------------- reference model ----------------
    // Transaction view: one port served at a time; a free arbiter grants the
    // single pending port, or the one not served last when both are pending;
    // a port whose completion is being signalled cannot be granted again yet.
    logic        m_valid = 1'b0, m_srv = 1'b0, m_port = 1'b0, m_last = 1'b1, m_issue = 1'b0;
    logic [1:0]  m_done = 2'b00;
    logic [31:0] m_data [2];
    logic [31:0] m_addr = 32'd0, m_wd = 32'd0;
    logic [1:0]  m_len = 2'b00;

    always @(negedge clk) begin
        logic pend_i, pend_d, g;
        logic [1:0] nd;
        if (m_valid) begin
            chk("i_busy", i_busy, m_srv && !m_port);
            chk("d_busy", d_busy, m_srv && m_port);
            chk("i_done", i_done, m_done[0]);
            chk("d_done", d_done, m_done[1]);
            chk("i_data_out", i_data_out, m_data[0]);
            chk("d_data_out", d_data_out, m_data[1]);
            chk("issue_strobe", rw_flag_out != 2'b00, m_issue);
            chk("addr_out", addr_out, m_addr);
            chk("len_out", len_out, m_len);
            chk("wdata_out", wdata_out, m_wd);
        end
        if (rst) begin
            m_valid = 1'b1; m_srv = 1'b0; m_last = 1'b1; m_issue = 1'b0; m_done = 2'b00;
            m_data[0] = 32'd0; m_data[1] = 32'd0;
            m_addr = 32'd0; m_wd = 32'd0; m_len = 2'b00;
        end else if (rdy && m_valid) begin
            nd = 2'b00;
            m_issue = 1'b0;
            if (!m_srv) begin
                pend_i = (i_rw_flag != 2'b00) && !m_done[0];
                pend_d = (d_rw_flag != 2'b00) && !m_done[1];
                if (pend_i || pend_d) begin
                    g = (pend_i && pend_d) ? !m_last : pend_d;
                    if (g) begin
                        m_addr = d_addr; m_len = d_len; m_wd = d_wdata;
                        q_iss.push_back('{d_rw_flag, d_addr, d_len, d_wdata});
                    end else begin
                        m_addr = i_addr; m_len = i_len; m_wd = 32'd0;
                        q_iss.push_back('{i_rw_flag, i_addr, i_len, 32'd0});
                    end
                    m_srv = 1'b1; m_port = g; m_last = g; m_issue = 1'b1;
                end
            end else if (mem_done) begin
                nd[m_port] = 1'b1;
                m_data[m_port] = read_data;
                if (m_port) q_dd.push_back(read_data);
                else        q_di.push_back(read_data);
                m_srv = 1'b0;
            end
            m_done = nd;
        end
    end

    // ---------------- monitor ----------------
    // Outputs only carry a new event when the last edge actually advanced.
    logic upd_prev = 1'b0;
    always @(negedge clk) begin
        iss_t e;
        if (upd_prev) begin
            if (rw_flag_out != 2'b00) begin
                if (q_iss.size() == 0) begin
                    total++; bad++;
                    $display("FAIL issue_unexpected: got addr %h, want no issue", addr_out);
                end else begin
                    e = q_iss.pop_front();
                    chk("iss_rw", rw_flag_out, e.rw);
                    chk("iss_addr", addr_out, e.addr);
                    chk("iss_len", len_out, e.len);
                    chk("iss_wdata", wdata_out, e.wd);
                end
            end
            if (i_done) begin
                if (q_di.size() == 0) begin
                    total++; bad++; $display("FAIL i_done_unexpected: got 1 want 0");
                end else chk("i_done_data", i_data_out, q_di.pop_front());
            end
            if (d_done) begin
                if (q_dd.size() == 0) begin
                    total++; bad++; $display("FAIL d_done_unexpected: got 1 want 0");
                end else chk("d_done_data", d_data_out, q_dd.pop_front());
            end
        end
        upd_prev = rdy && !rst;
    end

    // ---------------- memory model ----------------
    // Completes each issue 0..3 cycles later; shares rdy, so it stalls with it.
    int cnt = -1;
    initial forever begin
        @(posedge clk); #1;
        if (mem_manual) cnt = -1;
        else if (rst) begin
            mem_done = 1'b0; cnt = -1;
        end else if (rdy) begin
            mem_done = 1'b0;
            if (rw_flag_out != 2'b00) cnt = int'($urandom_range(0, 3));
            else if (cnt > 0) cnt--;
            if (cnt == 0) begin
                mem_done = 1'b1; read_data = $urandom; cnt = -1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic pulse_mem(input logic [31:0] data);
        mem_done = 1'b1; read_data = data;
        step();
        mem_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, port;
        // reset state
        repeat (2) step();
        rst = 1'b0;
        chk("rst_rw_flag_out", rw_flag_out, 2'b00);
        chk("rst_i_busy", i_busy, 1'b0);
        chk("rst_d_data_out", d_data_out, 32'd0);

        // single I read, memory answers 3 cycles after issue
        i_rw_flag = 2'b01; i_addr = 32'h1000; i_len = 2'd2;
        step();
        chk("rd_issue_flag", rw_flag_out, 2'b01);
        chk("rd_issue_addr", addr_out, 32'h1000);
        step(); step();
        pulse_mem(32'hDEADBEEF);
        chk("rd_i_done", i_done, 1'b1);
        chk("rd_i_data", i_data_out, 32'hDEADBEEF);
        i_rw_flag = 2'b00;
        step();

        // simultaneous requests after reset: I first, D right after i_done
        rst = 1'b1; step(); rst = 1'b0;
        i_rw_flag = 2'b01; i_addr = 32'h2000;
        d_rw_flag = 2'b10; d_addr = 32'h3000; d_wdata = 32'h55; d_len = 2'd1;
        step();
        chk("both_first_addr", addr_out, 32'h2000);
        step();
        pulse_mem(32'h11112222);
        chk("both_i_done", i_done, 1'b1);
        i_rw_flag = 2'b00;
        step();
        chk("both_d_flag", rw_flag_out, 2'b10);
        chk("both_d_addr", addr_out, 32'h3000);
        chk("both_d_wdata", wdata_out, 32'h55);
        pulse_mem(32'h33334444);
        d_rw_flag = 2'b00;
        step();

        // both held continuously: completions must alternate
        mem_manual = 1'b0;
        i_rw_flag = 2'b01; d_rw_flag = 2'b10;
        prev = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            port = i_done ? 0 : (d_done ? 1 : -1);
            if (port >= 0) begin
                if (prev >= 0) chk("alternate", port, prev ^ 1);
                prev = port;
            end
        end
        d_rw_flag = 2'b00;
        // I alone held: re-granted after each completion, no duplicate issue
        repeat (15) step();
        i_rw_flag = 2'b00;
        repeat (6) step();

        // reset while serving D, late mem_done ignored
        mem_manual = 1'b1;
        d_rw_flag = 2'b10; d_addr = 32'h4000; d_wdata = 32'hA5;
        step(); step();
        chk("rstmid_d_busy", d_busy, 1'b1);
        rst = 1'b1; d_rw_flag = 2'b00;
        step();
        rst = 1'b0;
        pulse_mem(32'h12345678);
        chk("rstmid_d_done", d_done, 1'b0);
        chk("rstmid_d_data", d_data_out, 32'd0);
        chk("rstmid_addr", addr_out, 32'd0);
        d_rw_flag = 2'b01; d_addr = 32'h4400;
        step(); step();
        pulse_mem(32'h87654321);
        chk("rstmid_next_done", d_done, 1'b1);
        d_rw_flag = 2'b00;
        step();

        // rdy low for 2 cycles mid-service
        i_rw_flag = 2'b01; i_addr = 32'h5000;
        step();
        rdy = 1'b0;
        step(); step();
        chk("stall_i_busy", i_busy, 1'b1);
        chk("stall_addr", addr_out, 32'h5000);
        rdy = 1'b1;
        step();
        pulse_mem(32'hCAFEF00D);
        chk("stall_done_data", i_data_out, 32'hCAFEF00D);
        i_rw_flag = 2'b00;
        step();

        // randomized traffic
        mem_manual = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            rdy = ($urandom % 10) != 0;
            rst = ($urandom % 300) == 0;
            mem_busy = $urandom % 2;
            if (i_done || i_rw_flag == 2'b00) begin
                if ($urandom % 4 == 0) i_rw_flag = 2'b00;
                else if (i_rw_flag == 2'b00 || $urandom % 2 == 1) begin
                    i_rw_flag = 2'($urandom_range(1, 3));
                    i_addr = $urandom; i_len = 2'($urandom);
                end
            end
            if (d_done || d_rw_flag == 2'b00) begin
                if ($urandom % 4 == 0) d_rw_flag = 2'b00;
                else if (d_rw_flag == 2'b00 || $urandom % 2 == 1) begin
                    d_rw_flag = 2'($urandom_range(1, 3));
                    d_addr = $urandom; d_len = 2'($urandom); d_wdata = $urandom;
                end
            end
        end
        rst = 1'b0; rdy = 1'b1; i_rw_flag = 2'b00; d_rw_flag = 2'b00;
        repeat (12) step();
        chk("drain_issue_q", q_iss.size(), 0);
        chk("drain_i_q", q_di.size(), 0);
        chk("drain_d_q", q_dd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
